// File: rtl/traffic_countdown_ctrl_if.sv
// Control/status bundle of the traffic countdown controller: timing inputs, mode inputs,
// light colours, countdowns and the 1 s tick.
interface traffic_countdown_ctrl_if #(
  parameter int CNT_W = 7
);
  logic [CNT_W-1:0] g_time_a;
  logic [CNT_W-1:0] g_time_b;
  logic [CNT_W-1:0] y_time;
  logic             hold;
  logic             night_mode;
  logic [2:0]       light_a;
  logic [2:0]       light_b;
  logic [CNT_W-1:0] counter_a;
  logic [CNT_W-1:0] counter_b;
  logic             tick;

  modport master (
    output g_time_a, g_time_b, y_time, hold, night_mode,
    input  light_a, light_b, counter_a, counter_b, tick
  );

  modport slave (
    input  g_time_a, g_time_b, y_time, hold, night_mode,
    output light_a, light_b, counter_a, counter_b, tick
  );
endinterface

// File: rtl/traffic_countdown_ctrl.sv
// Two-road traffic-light sequencer with per-road countdowns, hold and night-flash modes.
// Lights/counters are registered one cycle behind the phase state; free-running, no backpressure.
module traffic_countdown_ctrl #(
  parameter int CNT_W    = 7,
  parameter int TICK_DIV = 50000000,
  parameter int CLR_T    = 0
) (
  input  logic clk,
  input  logic rst_n,
  traffic_countdown_ctrl_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = CNT_W + 2;
  localparam logic [PW-1:0]    PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0]    SAT     = SW'((1 << CNT_W) - 1);
  localparam logic [SW-1:0]    CLR_S   = SW'(CLR_T);
  localparam logic [CNT_W-1:0] CLR_R   = CNT_W'(CLR_T);
  localparam logic [2:0] RED = 3'b100, YEL = 3'b010, GRN = 3'b001, OFF = 3'b000;

  typedef enum logic [2:0] {
    S_LOAD, S_AG, S_AY, S_CA, S_BG, S_BY, S_CB, S_FLASH
  } state_t;

  state_t           state, adv_state;
  logic [PW-1:0]    presc;
  logic [CNT_W-1:0] rem, ga, gb, yt, adv_dur, ga_in, gb_in, yt_in;
  logic             flash_on, tick_q, wrap;
  logic [2:0]       light_a_q, light_b_q, la_n, lb_n;
  logic [CNT_W-1:0] counter_a_q, counter_b_q, ca_n, cb_n;

  function automatic logic [CNT_W-1:0] sat(input logic [SW-1:0] v);
    return (v > SAT) ? CNT_W'(SAT) : v[CNT_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] min1(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  assign ga_in = min1(bus.g_time_a);
  assign gb_in = min1(bus.g_time_b);
  assign yt_in = min1(bus.y_time);
  assign wrap  = (presc == PRE_MAX);

  // Phase entered when rem expires; entering S_AG starts a new cycle with fresh durations.
  always_comb begin
    adv_state = S_AG;
    adv_dur   = ga_in;
    case (state)
      S_AG: begin adv_state = S_AY; adv_dur = yt; end
      S_AY: begin
        if (CLR_T == 0) begin adv_state = S_BG; adv_dur = gb; end
        else begin adv_state = S_CA; adv_dur = CLR_R; end
      end
      S_CA: begin adv_state = S_BG; adv_dur = gb; end
      S_BG: begin adv_state = S_BY; adv_dur = yt; end
      S_BY: begin
        if (CLR_T != 0) begin adv_state = S_CB; adv_dur = CLR_R; end
      end
      default: ;
    endcase
  end

  // Each counter is the time until that road's colour next changes.
  always_comb begin
    la_n = RED;
    lb_n = RED;
    ca_n = '0;
    cb_n = '0;
    case (state)
      S_AG: begin la_n = GRN; ca_n = rem; cb_n = sat(SW'(rem) + SW'(yt) + CLR_S); end
      S_AY: begin la_n = YEL; ca_n = rem; cb_n = sat(SW'(rem) + CLR_S); end
      S_CA: begin ca_n = sat(SW'(rem) + SW'(gb) + SW'(yt) + CLR_S); cb_n = rem; end
      S_BG: begin lb_n = GRN; cb_n = rem; ca_n = sat(SW'(rem) + SW'(yt) + CLR_S); end
      S_BY: begin lb_n = YEL; cb_n = rem; ca_n = sat(SW'(rem) + CLR_S); end
      S_CB: begin ca_n = rem; cb_n = sat(SW'(rem) + SW'(ga) + SW'(yt) + CLR_S); end
      S_FLASH: begin
        la_n = flash_on ? YEL : OFF;
        lb_n = flash_on ? YEL : OFF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_LOAD;
      presc       <= '0;
      rem         <= '0;
      ga          <= CNT_W'(1);
      gb          <= CNT_W'(1);
      yt          <= CNT_W'(1);
      flash_on    <= 1'b0;
      tick_q      <= 1'b0;
      light_a_q   <= RED;
      light_b_q   <= RED;
      counter_a_q <= '0;
      counter_b_q <= '0;
    end else begin
      tick_q      <= 1'b0;
      light_a_q   <= la_n;
      light_b_q   <= lb_n;
      counter_a_q <= ca_n;
      counter_b_q <= cb_n;
      if (bus.night_mode) begin
        if (state != S_FLASH) begin
          state    <= S_FLASH;
          presc    <= '0;
          rem      <= '0;
          flash_on <= 1'b1;
        end else if (wrap) begin
          presc    <= '0;
          tick_q   <= 1'b1;
          flash_on <= ~flash_on;
        end else begin
          presc <= presc + PW'(1);
        end
      end else if (state == S_FLASH) begin
        state <= S_LOAD;
        presc <= '0;
      end else if (!bus.hold) begin
        if (state == S_LOAD) begin
          ga    <= ga_in;
          gb    <= gb_in;
          yt    <= yt_in;
          rem   <= ga_in;
          presc <= '0;
          state <= S_AG;
        end else if (wrap) begin
          presc  <= '0;
          tick_q <= 1'b1;
          if (rem > CNT_W'(1)) begin
            rem <= rem - CNT_W'(1);
          end else begin
            state <= adv_state;
            rem   <= adv_dur;
            if (adv_state == S_AG) begin
              ga <= ga_in;
              gb <= gb_in;
              yt <= yt_in;
            end
          end
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

  assign bus.light_a   = light_a_q;
  assign bus.light_b   = light_b_q;
  assign bus.counter_a = counter_a_q;
  assign bus.counter_b = counter_b_q;
  assign bus.tick      = tick_q;
endmodule

// File: tb/tb_traffic_countdown_ctrl.sv
// Bench: two controllers (no clearance / 1 s clearance) on shared stimulus, checked every cycle
// against a phase-timeline model plus a few hand-computed points.
module tb_traffic_countdown_ctrl;
  localparam int CW  = 7;
  localparam int TD  = 4;
  localparam int MAXV = (1 << CW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  bit   armed = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  traffic_countdown_ctrl_if #(.CNT_W(CW)) bus0 ();
  traffic_countdown_ctrl_if #(.CNT_W(CW)) bus1 ();

  traffic_countdown_ctrl #(.CNT_W(CW), .TICK_DIV(TD), .CLR_T(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  traffic_countdown_ctrl #(.CNT_W(CW), .TICK_DIV(TD), .CLR_T(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  // Model: mode 0 = load, 1 = running phase ph, 2 = flashing; el = active cycles in phase/flash.
  int mode[2], ph[2], el[2], lga[2], lgb[2], lyt[2];
  int e_la[2], e_lb[2], e_ca[2], e_cb[2], e_tk[2];
  int clr_of[2] = '{0, 1};
  // Phase order AG, AY, CA, BG, BY, CB; colour codes 1=green 2=yellow 4=red.
  int col_a[6] = '{1, 2, 4, 4, 4, 4};
  int col_b[6] = '{4, 4, 4, 1, 2, 4};

  function automatic int dur(int k, int p);
    case (p)
      0: return lga[k];
      1: return lyt[k];
      3: return lgb[k];
      4: return lyt[k];
      default: return clr_of[k];
    endcase
  endfunction

  function automatic int next_phase(int k, int p);
    int q = p;
    for (int i = 0; i < 6; i++) begin
      q = (q + 1) % 6;
      if (dur(k, q) != 0) break;
    end
    return q;
  endfunction

  function automatic int until_change(int k, bit road_b);
    int own, total, q;
    own   = road_b ? col_b[ph[k]] : col_a[ph[k]];
    total = dur(k, ph[k]) - el[k] / TD;
    q     = ph[k];
    for (int i = 0; i < 5; i++) begin
      q = (q + 1) % 6;
      if ((road_b ? col_b[q] : col_a[q]) != own) break;
      total += dur(k, q);
    end
    return (total > MAXV) ? MAXV : total;
  endfunction

  task automatic latch_times(int k);
    lga[k] = (bus0.g_time_a == 0) ? 1 : int'(bus0.g_time_a);
    lgb[k] = (bus0.g_time_b == 0) ? 1 : int'(bus0.g_time_b);
    lyt[k] = (bus0.y_time == 0) ? 1 : int'(bus0.y_time);
  endtask

  task automatic m_reset(int k);
    mode[k] = 0; ph[k] = 0; el[k] = 0;
    e_la[k] = 4; e_lb[k] = 4; e_ca[k] = 0; e_cb[k] = 0; e_tk[k] = 0;
  endtask

  task automatic m_step(int k);
    e_tk[k] = 0;
    if (mode[k] == 1) begin
      e_la[k] = col_a[ph[k]];
      e_lb[k] = col_b[ph[k]];
      e_ca[k] = until_change(k, 1'b0);
      e_cb[k] = until_change(k, 1'b1);
    end else if (mode[k] == 2) begin
      e_la[k] = ((el[k] / TD) % 2 == 0) ? 2 : 0;
      e_lb[k] = e_la[k];
      e_ca[k] = 0;
      e_cb[k] = 0;
    end else begin
      e_la[k] = 4; e_lb[k] = 4; e_ca[k] = 0; e_cb[k] = 0;
    end
    if (bus0.night_mode) begin
      if (mode[k] != 2) begin
        mode[k] = 2;
        el[k]   = 0;
      end else begin
        el[k]++;
        if (el[k] % TD == 0) e_tk[k] = 1;
      end
    end else if (mode[k] == 2) begin
      mode[k] = 0;
    end else if (!bus0.hold) begin
      if (mode[k] == 0) begin
        latch_times(k);
        mode[k] = 1; ph[k] = 0; el[k] = 0;
      end else begin
        el[k]++;
        if (el[k] % TD == 0) e_tk[k] = 1;
        if (el[k] == dur(k, ph[k]) * TD) begin
          el[k] = 0;
          ph[k] = next_phase(k, ph[k]);
          if (ph[k] == 0) latch_times(k);
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reset(0);
      m_reset(1);
    end else begin
      m_step(0);
      m_step(1);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input int k, input logic [2:0] la, input logic [2:0] lb,
                     input logic [CW-1:0] ca, input logic [CW-1:0] cb, input logic tk);
    chk($sformatf("dut%0d light_a", k), int'(la), e_la[k]);
    chk($sformatf("dut%0d light_b", k), int'(lb), e_lb[k]);
    chk($sformatf("dut%0d counter_a", k), int'(ca), e_ca[k]);
    chk($sformatf("dut%0d counter_b", k), int'(cb), e_cb[k]);
    chk($sformatf("dut%0d tick", k), int'(tk), e_tk[k]);
  endtask

  always @(negedge clk) begin
    if (armed) begin
      cmp(0, bus0.light_a, bus0.light_b, bus0.counter_a, bus0.counter_b, bus0.tick);
      cmp(1, bus1.light_a, bus1.light_b, bus1.counter_a, bus1.counter_b, bus1.tick);
    end
  end

  task automatic drive(input int ga, input int gb, input int yt, input bit hd, input bit nm);
    bus0.g_time_a = CW'(ga); bus1.g_time_a = CW'(ga);
    bus0.g_time_b = CW'(gb); bus1.g_time_b = CW'(gb);
    bus0.y_time   = CW'(yt); bus1.y_time   = CW'(yt);
    bus0.hold     = hd;      bus1.hold     = hd;
    bus0.night_mode = nm;    bus1.night_mode = nm;
  endtask

  task automatic after_edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int ga, gb, yt, len, hmode;
    bit nm;
    drive(5, 3, 2, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    armed = 1'b1;
    chk("reset light_a", int'(bus0.light_a), 4);
    chk("reset light_b", int'(bus1.light_b), 4);
    chk("reset counter_b", int'(bus1.counter_b), 0);
    chk("reset tick", int'(bus0.tick), 0);

    @(posedge clk); #2 rst_n = 1'b1;
    after_edges(1);
    chk("load all-red", int'(bus0.light_a), 4);
    after_edges(1);
    chk("AG light_a", int'(bus0.light_a), 1);
    chk("AG light_b", int'(bus0.light_b), 4);
    chk("AG counter_a", int'(bus0.counter_a), 5);
    chk("AG counter_b", int'(bus0.counter_b), 7);
    chk("model AG counter_b", e_cb[0], 7);
    chk("AG clr counter_b", int'(bus1.counter_b), 8);
    after_edges(3);
    chk("first tick", int'(bus0.tick), 1);
    after_edges(1);
    chk("AG counter_a step", int'(bus0.counter_a), 4);
    after_edges(16);
    chk("AY light_a", int'(bus0.light_a), 2);
    chk("AY counter_a", int'(bus0.counter_a), 2);
    chk("AY counter_b", int'(bus0.counter_b), 2);
    after_edges(8);
    chk("CA light_a", int'(bus1.light_a), 4);
    chk("CA light_b", int'(bus1.light_b), 4);
    chk("CA counter_a", int'(bus1.counter_a), 7);
    chk("model CA counter_a", e_ca[1], 7);
    chk("CA counter_b", int'(bus1.counter_b), 1);
    after_edges(4);
    chk("BG light_b", int'(bus1.light_b), 1);
    chk("BG counter_a", int'(bus1.counter_a), 6);
    chk("BG counter_b", int'(bus1.counter_b), 3);

    // Saturation: 120 s green with 20 s yellow.
    @(posedge clk); #2 rst_n = 1'b0;
    drive(120, 3, 20, 1'b0, 1'b0);
    @(posedge clk); #2 rst_n = 1'b1;
    after_edges(2);
    chk("sat counter_a", int'(bus0.counter_a), 120);
    chk("sat counter_b", int'(bus0.counter_b), 127);
    chk("model sat counter_b", e_cb[0], 127);
    chk("sat clr counter_b", int'(bus1.counter_b), 127);

    drive(120, 3, 20, 1'b1, 1'b0);
    after_edges(10);
    drive(120, 3, 20, 1'b0, 1'b1);
    after_edges(3);
    chk("flash light_a", int'(bus0.light_a), 2);
    chk("flash counter_a", int'(bus1.counter_a), 0);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("async rst light_a", int'(bus0.light_a), 4);
    chk("async rst light_b", int'(bus1.light_b), 4);
    chk("async rst tick", int'(bus1.tick), 0);
    @(posedge clk); #2 drive(5, 3, 2, 1'b0, 1'b0); rst_n = 1'b1;

    for (int seg = 0; seg < 40; seg++) begin
      ga    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(100, 127)) : int'($urandom_range(0, 6));
      gb    = int'($urandom_range(0, 6));
      yt    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(15, 30)) : int'($urandom_range(0, 5));
      nm    = ($urandom_range(0, 6) == 0);
      hmode = int'($urandom_range(0, 2));
      len   = int'($urandom_range(30, 250));
      if ($urandom_range(0, 9) == 0) begin
        @(posedge clk); #2 rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
      end
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        drive(ga, gb, yt,
              (hmode == 1) ? ($urandom_range(0, 7) == 0) : (hmode == 2 && c >= 10 && c < 20),
              nm);
      end
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
